ext_pipe: RTL and testbench



---
 rtl/ext_pipe_pkg.sv | 19 +
 rtl/ext_pipe_core.sv | 34 +++
 rtl/ext_pipe.sv | 84 ++++++++
 tb/tb_ext_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ext_pkg
// Brief   : Shared types and constants for the extension unit.
// Rev     : 1.0  initial release
// ============================================================================
package ext_pkg;

  localparam int EXT_MODE_W = 2;

  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_ZERO = 2'b00,  // zero-fill upper bits
    EXT_SIGN = 2'b01,  // replicate the input MSB
    EXT_HIGH = 2'b10,  // place the input in the upper bits (lui-style)
    EXT_ONES = 2'b11   // one-fill upper bits
  } ext_mode_t;

endpackage : ext_pkg
`default_nettype wire

// File: rtl/ext_pipe_core.sv
`default_nettype none
// ============================================================================
// Module  : ext_core
// Brief   : Combinational IN_W -> OUT_W extender, four modes. Usable on its
//           own as the single-cycle datapath extender.
// Rev     : 1.0  initial release
// ============================================================================
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]       data_i,
  input  logic [EXT_MODE_W-1:0] mode_i,
  output logic [OUT_W-1:0]      data_o
);

  localparam int PAD_W = OUT_W - IN_W;

  // Select the extended value for the requested mode
  always_comb begin
    data_o = {{PAD_W{1'b0}}, data_i};
    case (mode_i)
      EXT_ZERO: data_o = {{PAD_W{1'b0}}, data_i};
      EXT_SIGN: data_o = {{PAD_W{data_i[IN_W-1]}}, data_i};
      EXT_HIGH: data_o = {data_i, {PAD_W{1'b0}}};
      EXT_ONES: data_o = {{PAD_W{1'b1}}, data_i};
      default:  data_o = {{PAD_W{1'b0}}, data_i};
    endcase
  end

endmodule : ext_core
`default_nettype wire

// File: rtl/ext_pipe.sv
`default_nettype none
// ============================================================================
// Module  : ext_pipe
// Brief   : Extension unit followed by a STAGES-deep valid/ready pipeline
//           with bubble collapsing.
// Rev     : 1.0  initial release
// ============================================================================
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic [EXT_MODE_W-1:0] in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  busy
);

  logic [OUT_W-1:0]  ext_d;
  logic [STAGES-1:0] valid_q;
  logic [OUT_W-1:0]  data_q [STAGES];
  logic [STAGES-1:0] load;
  // Candidate contents for each stage: what it takes when it loads
  logic [STAGES-1:0] valid_d;
  logic [OUT_W-1:0]  data_d [STAGES];

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .data_i (in_data),
    .mode_i (in_mode),
    .data_o (ext_d)
  );

  // A stage is blocked only when it and every stage below it hold a beat
  // and the consumer is stalling; expressed per stage so the ready chain is
  // a flat AND rather than a loop through the load vector.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign load[k] = ~((&valid_q[STAGES-1:k]) & ~out_ready);
    if (k == 0) begin : g_head
      assign valid_d[k] = in_valid;
      assign data_d[k]  = ext_d;
    end else begin : g_body
      assign valid_d[k] = valid_q[k-1];
      assign data_d[k]  = data_q[k-1];
    end
  end

  // Advance each stage that loads; data only moves with a valid beat so
  // emptied stages keep their last value instead of picking up stale data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= valid_d[k];
          if (valid_d[k]) begin
            data_q[k] <= data_d[k];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign busy      = |valid_q;

endmodule : ext_pipe
`default_nettype wire

// File: tb/tb_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_ext_pipe
// Brief   : Directed self-checking bench for ext_pipe (main 16/32/2 instance
//           plus 8/16 instances with 1 and 4 stages).
// Rev     : 1.0  initial release
// ============================================================================
module tb_ext_pipe;

  localparam int P_STAGES = 2;

  logic clk = 1'b0;
  logic rst_n;

  // main instance
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [31:0] out_data;

  // 8->16, one stage
  logic        s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready, s1_busy;
  logic [7:0]  s1_in_data;
  logic [1:0]  s1_in_mode;
  logic [15:0] s1_out_data;

  // 8->16, four stages
  logic        s4_in_valid, s4_in_ready, s4_out_valid, s4_out_ready, s4_busy;
  logic [7:0]  s4_in_data;
  logic [1:0]  s4_in_mode;
  logic [15:0] s4_out_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(P_STAGES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  ext_pipe #(.IN_W(8), .OUT_W(16), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data), .in_mode(s1_in_mode),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data), .busy(s1_busy)
  );

  ext_pipe #(.IN_W(8), .OUT_W(16), .STAGES(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s4_in_valid), .in_ready(s4_in_ready), .in_data(s4_in_data), .in_mode(s4_in_mode),
    .out_valid(s4_out_valid), .out_ready(s4_out_ready), .out_data(s4_out_data), .busy(s4_busy)
  );

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
    #5 rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_modes();
    logic [15:0] din [8];
    logic [1:0]  dmode [8];
    logic [31:0] dexp [8];
    int lat;
    din = '{16'h007B, 16'h007B, 16'h007B, 16'h007B, 16'hFF85, 16'hFF85, 16'hFF85, 16'hFF85};
    dmode = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    dexp = '{32'h0000007B, 32'h0000007B, 32'h007B0000, 32'hFFFF007B,
             32'h0000FF85, 32'hFFFFFF85, 32'hFF850000, 32'hFFFFFF85};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = din[i]; in_mode = dmode[i];
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mode%0d_in_ready got=%b exp=1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 8) begin tick(); lat++; end
      n_cmp++; if (lat !== P_STAGES - 1) begin n_err++; $display("FAIL mode%0d_latency got=%0d exp=%0d", i, lat, P_STAGES - 1); end
      n_cmp++; if (out_data !== dexp[i]) begin n_err++; $display("FAIL mode%0d_data got=%h exp=%h", i, out_data, dexp[i]); end
      tick();
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8); in_data = 16'(c + 1); in_mode = 2'b01;
      #1;
      if (c < 8) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      n_cmp++; if (out_valid !== (c >= 2 && c < 10)) begin n_err++; $display("FAIL stream_out_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 2 && c < 10)); end
      if (c >= 2 && c < 10) begin
        n_cmp++; if (out_data !== 32'(c - 1)) begin n_err++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, out_data, 32'(c - 1)); end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = 16'(16'h1111 * (c + 1)); in_mode = (c < 2) ? 2'b00 : 2'b11;
      #1;
      if (in_ready === 1'b1) acc++;
      if (c >= 2) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00001111) begin
          n_err++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/00001111", c, out_valid, out_data);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (acc !== 2) begin n_err++; $display("FAIL bp_accepted got=%0d exp=2", acc); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00001111) begin n_err++; $display("FAIL bp_drain0 got=%b/%h exp=1/00001111", out_valid, out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00002222) begin n_err++; $display("FAIL bp_drain1 got=%b/%h exp=1/00002222", out_valid, out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_empty got=%b/%b exp=0/0", out_valid, busy); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b01;
    in_data = 16'h0C0C; tick();
    in_data = 16'h0D0D; tick();
    in_data = 16'h8E8E;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pushpop_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_data !== 32'h00000C0C) begin n_err++; $display("FAIL pushpop_out got=%h exp=00000C0C", out_data); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00000D0D) begin n_err++; $display("FAIL pushpop_next got=%b/%h exp=1/00000D0D", out_valid, out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL pushpop_still_full got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF8E8E) begin n_err++; $display("FAIL pushpop_last got=%b/%h exp=1/FFFF8E8E", out_valid, out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL pushpop_empty got=%b/%b exp=0/0", out_valid, busy); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00;
    in_data = 16'h0011; tick();
    in_data = 16'h0022; tick();
    in_valid = 1'b0;
    #2;
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre got=%b/%b exp=1/1", busy, out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_async got=%b/%b exp=0/0", out_valid, busy); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_async_data got=%h exp=00000000", out_data); end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_stale c=%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  task automatic test_sweep();
    logic [1:0]  smode [2];
    logic [15:0] sexp [2];
    int lat;
    smode = '{2'b01, 2'b10};
    sexp  = '{16'hFF80, 16'h8000};
    s1_out_ready = 1'b1;
    s4_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s1_in_valid = 1'b1; s1_in_data = 8'h80; s1_in_mode = smode[i];
      tick();
      s1_in_valid = 1'b0;
      lat = 0;
      while (s1_out_valid !== 1'b1 && lat < 8) begin tick(); lat++; end
      n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL s1_latency%0d got=%0d exp=0", i, lat); end
      n_cmp++; if (s1_out_data !== sexp[i]) begin n_err++; $display("FAIL s1_data%0d got=%h exp=%h", i, s1_out_data, sexp[i]); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      s4_in_valid = 1'b1; s4_in_data = 8'h80; s4_in_mode = smode[i];
      tick();
      s4_in_valid = 1'b0;
      lat = 0;
      while (s4_out_valid !== 1'b1 && lat < 12) begin tick(); lat++; end
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL s4_latency%0d got=%0d exp=3", i, lat); end
      n_cmp++; if (s4_out_data !== sexp[i]) begin n_err++; $display("FAIL s4_data%0d got=%h exp=%h", i, s4_out_data, sexp[i]); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
    s1_in_valid = 1'b0; s1_in_data = '0; s1_in_mode = '0; s1_out_ready = 1'b0;
    s4_in_valid = 1'b0; s4_in_data = '0; s4_in_mode = '0; s4_out_ready = 1'b0;
    test_reset();
    test_modes();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_ext_pipe
`default_nettype wire
